// File: rtl/sequenciador_motor_uc_if.sv
// rtl/sequenciador_motor_uc_if.sv - command/completion handshake between control unit and move sequencer
//
// Purpose: groups the move request (iniciar, face, tipo) and the status/completion
// signals (ocupado, fim_movimento, erro) exchanged between the main control unit
// and sequenciador_motor_uc.
// Modports:
//   master - control unit side: drives iniciar/face/tipo, observes status
//   slave  - sequencer side: samples the request, drives status
interface sequenciador_motor_uc_if;
   logic       iniciar;
   logic [2:0] face;
   logic [1:0] tipo;
   logic       ocupado;
   logic       fim_movimento;
   logic       erro;

   modport master (
      output iniciar,
      output face,
      output tipo,
      input  ocupado,
      input  fim_movimento,
      input  erro
   );

   modport slave (
      input  iniciar,
      input  face,
      input  tipo,
      output ocupado,
      output fim_movimento,
      output erro
   );
endinterface

// File: rtl/sequenciador_motor_uc.sv
// rtl/sequenciador_motor_uc.sv - sequences one cube-face stepper move per handshake
//
// Purpose: on an iniciar request latches face/tipo, drives step/direction pulses
// to the selected one of six stepper drivers, waits for the motor to settle and
// reports completion with a one-cycle fim_movimento pulse (erro alongside it
// for an invalid command).
// Ports:
//   clock, reset   - system clock, synchronous active-high reset
//   cmd (slave)    - iniciar/face/tipo request, ocupado/fim_movimento/erro status
//   passo[5:0]     - step lines, only the latched face ever toggles
//   direcao[5:0]   - direction lines, 1 = CW
//   db_estado[2:0] - encoded current state
//   habilita_motor[5:0] - active-low driver enables, present only when
//                         MOTOR_ENABLE_EN is defined
// Parameters: STEPS_90, HALF_PERIOD, SETTLE_CYCLES.
module sequenciador_motor_uc #(
   parameter int STEPS_90      = 50,
   parameter int HALF_PERIOD   = 2500,
   parameter int SETTLE_CYCLES = 50000
) (
   input  logic                       clock,
   input  logic                       reset,
   sequenciador_motor_uc_if.slave     cmd,
   output logic [5:0]                 passo,
   output logic [5:0]                 direcao,
`ifdef MOTOR_ENABLE_EN
   output logic [5:0]                 habilita_motor,
`endif
   output logic [2:0]                 db_estado
);

   localparam int SW = $clog2(2 * STEPS_90 + 1);
   localparam int PW = $clog2(HALF_PERIOD + 1);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      CARREGA     = 3'd1,
      PASSO_ALTO  = 3'd2,
      PASSO_BAIXO = 3'd3,
      ASSENTA     = 3'd4,
      FIM         = 3'd5
   } state_t;

   state_t          state;
   logic [2:0]      face_l;
   logic [1:0]      tipo_l;
   logic            invalido;
   logic [SW-1:0]   alvo;
   logic [SW-1:0]   cnt_passo;
   logic [PW-1:0]   cnt_fase;
   logic [CW-1:0]   cnt_assenta;
   logic [SW-1:0]   cnt_passo_prox;

   function automatic logic [5:0] onehot(input logic [2:0] f);
      onehot = 6'b000001 << f;
   endfunction

   function automatic logic comando_valido(input logic [2:0] f, input logic [1:0] t);
      comando_valido = (f < 3'd6) && (t != 2'b11);
   endfunction

   assign cnt_passo_prox = cnt_passo + 1'b1;
   assign db_estado      = state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= IDLE;
         face_l            <= 3'd0;
         tipo_l            <= 2'd0;
         invalido          <= 1'b0;
         alvo              <= '0;
         cnt_passo         <= '0;
         cnt_fase          <= '0;
         cnt_assenta       <= '0;
         passo             <= 6'd0;
         direcao           <= 6'd0;
         cmd.ocupado       <= 1'b0;
         cmd.fim_movimento <= 1'b0;
         cmd.erro          <= 1'b0;
`ifdef MOTOR_ENABLE_EN
         habilita_motor    <= 6'b111111;
`endif
      end else begin
         cmd.fim_movimento <= 1'b0;
         cmd.erro          <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd.iniciar) begin
                  face_l      <= cmd.face;
                  tipo_l      <= cmd.tipo;
                  invalido    <= !comando_valido(cmd.face, cmd.tipo);
                  cmd.ocupado <= 1'b1;
                  state       <= CARREGA;
                  // Direction is registered on entry to CARREGA so it is stable
                  // for the whole CARREGA cycle before the first step rises.
                  if (comando_valido(cmd.face, cmd.tipo)) begin
                     direcao <= onehot(cmd.face) & {6{cmd.tipo != 2'b01}};
`ifdef MOTOR_ENABLE_EN
                     habilita_motor <= ~onehot(cmd.face);
`endif
                  end
               end
            end
            CARREGA: begin
               if (invalido) begin
                  cmd.fim_movimento <= 1'b1;
                  cmd.erro          <= 1'b1;
                  state             <= FIM;
               end else begin
                  alvo      <= (tipo_l == 2'b10) ? SW'(2 * STEPS_90) : SW'(STEPS_90);
                  cnt_passo <= '0;
                  cnt_fase  <= '0;
                  passo     <= onehot(face_l);
                  state     <= PASSO_ALTO;
               end
            end
            PASSO_ALTO: begin
               if (cnt_fase == PW'(HALF_PERIOD - 1)) begin
                  cnt_fase <= '0;
                  passo    <= 6'd0;
                  state    <= PASSO_BAIXO;
               end else begin
                  cnt_fase <= cnt_fase + 1'b1;
               end
            end
            PASSO_BAIXO: begin
               if (cnt_fase == PW'(HALF_PERIOD - 1)) begin
                  cnt_fase  <= '0;
                  cnt_passo <= cnt_passo_prox;
                  if (cnt_passo_prox == alvo) begin
                     cnt_assenta <= '0;
                     state       <= ASSENTA;
                  end else begin
                     passo <= onehot(face_l);
                     state <= PASSO_ALTO;
                  end
               end else begin
                  cnt_fase <= cnt_fase + 1'b1;
               end
            end
            ASSENTA: begin
               if (cnt_assenta == CW'(SETTLE_CYCLES - 1)) begin
                  cmd.fim_movimento <= 1'b1;
                  direcao           <= 6'd0;
`ifdef MOTOR_ENABLE_EN
                  habilita_motor    <= 6'b111111;
`endif
                  state             <= FIM;
               end else begin
                  cnt_assenta <= cnt_assenta + 1'b1;
               end
            end
            FIM: begin
               cmd.ocupado <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               passo       <= 6'd0;
               direcao     <= 6'd0;
               cmd.ocupado <= 1'b0;
`ifdef MOTOR_ENABLE_EN
               habilita_motor <= 6'b111111;
`endif
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sequenciador_motor_uc.sv
// tb/tb_sequenciador_motor_uc.sv - directed vector bench for sequenciador_motor_uc
module tb_sequenciador_motor_uc;
   localparam int STEPS_90      = 4;
   localparam int HALF_PERIOD   = 2;
   localparam int SETTLE_CYCLES = 3;

   logic       clock = 1'b0;
   logic       reset;
   logic [5:0] passo;
   logic [5:0] direcao;
   logic [2:0] db_estado;
`ifdef MOTOR_ENABLE_EN
   logic [5:0] habilita_motor;
`endif

   sequenciador_motor_uc_if cmd ();

   sequenciador_motor_uc #(
      .STEPS_90     (STEPS_90),
      .HALF_PERIOD  (HALF_PERIOD),
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .cmd      (cmd.slave),
      .passo    (passo),
      .direcao  (direcao),
`ifdef MOTOR_ENABLE_EN
      .habilita_motor(habilita_motor),
`endif
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [2:0] face;
      logic [1:0] tipo;
      int         pulses;
      logic [5:0] dir;
      int         lat;
      logic       err;
   } vec_t;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Issues one request and follows the move cycle by cycle up to fim_movimento.
   // intr_at > 0 pulses a second iniciar (to intr_face) in that cycle of the move.
   task automatic run_move(input vec_t v, input int intr_at, input logic [2:0] intr_face);
      logic [5:0] mask;
      int rises, highs, stray, dir_bad, occ_bad, err_stray, hab_bad, lat;
      logic prev, cur, err_seen;
      mask = (v.pulses > 0) ? (6'b000001 << v.face) : 6'd0;
      rises = 0; highs = 0; stray = 0; dir_bad = 0; occ_bad = 0;
      err_stray = 0; hab_bad = 0; lat = -1; prev = 1'b0; err_seen = 1'b0;
      cmd.face    = v.face;
      cmd.tipo    = v.tipo;
      cmd.iniciar = 1'b1;
      tick();
      cmd.iniciar = 1'b0;
      for (int c = 1; c < 200; c++) begin
         cur = |(passo & mask);
         if (cur && !prev) rises++;
         if (cur) highs++;
         prev = cur;
         if ((passo & ~mask) != 6'd0) stray++;
         if (!cmd.fim_movimento && direcao != v.dir) dir_bad++;
         if (!cmd.ocupado) occ_bad++;
         if (cmd.erro && !cmd.fim_movimento) err_stray++;
`ifdef MOTOR_ENABLE_EN
         if (habilita_motor != ((v.pulses > 0 && !cmd.fim_movimento) ? ~mask : 6'b111111)) hab_bad++;
`endif
         if (cmd.fim_movimento) begin
            lat = c;
            err_seen = cmd.erro;
            break;
         end
         if (c == intr_at) begin
            cmd.face    = intr_face;
            cmd.tipo    = 2'b00;
            cmd.iniciar = 1'b1;
         end else begin
            cmd.iniciar = 1'b0;
         end
         tick();
      end
      cmd.iniciar = 1'b0;
      chk("latency", lat, v.lat);
      chk("pulse_count", rises, v.pulses);
      chk("high_cycles", highs, v.pulses * HALF_PERIOD);
      chk("stray_passo", stray, 0);
      chk("direcao", dir_bad, 0);
      chk("ocupado", occ_bad, 0);
      chk("erro_at_fim", int'(err_seen), int'(v.err));
      chk("erro_stray", err_stray, 0);
`ifdef MOTOR_ENABLE_EN
      chk("habilita_motor", hab_bad, 0);
`endif
      tick();
      chk("post_fim_pulse", int'(cmd.fim_movimento), 0);
      chk("post_ocupado", int'(cmd.ocupado), 0);
      chk("post_estado", int'(db_estado), 0);
      chk("post_direcao", int'(direcao), 0);
   endtask

   vec_t vecs[8];
   vec_t v;

   initial begin
      // Valid move latency = 2 + 2*HALF_PERIOD*N + SETTLE_CYCLES; invalid = 2.
      vecs[0] = '{3'd2, 2'b00, 4, 6'b000100, 21, 1'b0};
      vecs[1] = '{3'd5, 2'b01, 4, 6'b000000, 21, 1'b0};
      vecs[2] = '{3'd0, 2'b10, 8, 6'b000001, 37, 1'b0};
      vecs[3] = '{3'd6, 2'b00, 0, 6'b000000,  2, 1'b1};
      vecs[4] = '{3'd1, 2'b11, 0, 6'b000000,  2, 1'b1};
      vecs[5] = '{3'd3, 2'b01, 4, 6'b000000, 21, 1'b0};
      vecs[6] = '{3'd7, 2'b10, 0, 6'b000000,  2, 1'b1};
      vecs[7] = '{3'd4, 2'b10, 8, 6'b010000, 37, 1'b0};

      cmd.iniciar = 1'b0;
      cmd.face    = 3'd0;
      cmd.tipo    = 2'b00;
      reset       = 1'b1;
      tick();
      tick();
      chk("reset_passo", int'(passo), 0);
      chk("reset_direcao", int'(direcao), 0);
      chk("reset_ocupado", int'(cmd.ocupado), 0);
      chk("reset_fim", int'(cmd.fim_movimento), 0);
      chk("reset_erro", int'(cmd.erro), 0);
      chk("reset_estado", int'(db_estado), 0);
`ifdef MOTOR_ENABLE_EN
      chk("reset_habilita", int'(habilita_motor), 63);
`endif
      reset = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) run_move(vecs[i], -1, 3'd0);

      // Back-to-back: new move starts the cycle right after FIM.
      run_move(vecs[0], -1, 3'd0);

      // Second iniciar mid-move must be ignored: face 3 never steps, no queued move.
      v = '{3'd1, 2'b00, 4, 6'b000010, 21, 1'b0};
      run_move(v, 6, 3'd3);
      tick();
      chk("no_queued_move", int'(cmd.ocupado), 0);

      // Reset during PASSO_ALTO aborts the move.
      cmd.face    = 3'd4;
      cmd.tipo    = 2'b00;
      cmd.iniciar = 1'b1;
      tick();
      cmd.iniciar = 1'b0;
      tick();
      chk("alto_passo", int'(passo), 16);
      chk("alto_estado", int'(db_estado), 2);
      reset = 1'b1;
      tick();
      chk("abort_passo", int'(passo), 0);
      chk("abort_estado", int'(db_estado), 0);
      chk("abort_ocupado", int'(cmd.ocupado), 0);
      chk("abort_direcao", int'(direcao), 0);
      reset = 1'b0;
      tick();
      v = '{3'd4, 2'b00, 4, 6'b010000, 21, 1'b0};
      run_move(v, -1, 3'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
